// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-ported data memory
// between the CPU load/store unit (port 0) and the program/debug loader (port 1).
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      p0_req_valid,
    output logic                      p0_req_ready,
    input  logic                      p0_req_we,
    input  logic [DATA_WIDTH-1:0]     p0_req_addr,
    input  logic [DATA_WIDTH-1:0]     p0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   p0_req_be,
    output logic                      p0_rsp_valid,
    input  logic                      p0_rsp_ready,
    output logic [DATA_WIDTH-1:0]     p0_rsp_rdata,
    output logic                      p0_rsp_err,

    input  logic                      p1_req_valid,
    output logic                      p1_req_ready,
    input  logic                      p1_req_we,
    input  logic [DATA_WIDTH-1:0]     p1_req_addr,
    input  logic [DATA_WIDTH-1:0]     p1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   p1_req_be,
    output logic                      p1_rsp_valid,
    input  logic                      p1_rsp_ready,
    output logic [DATA_WIDTH-1:0]     p1_rsp_rdata,
    output logic                      p1_rsp_err,

    output logic                      mem_en,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic                     last_grant;
    logic                     owner;
    logic                     lat_we;
    logic                     lat_err;
    logic [ADDRESS_WIDTH-1:0] lat_widx;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [BE_WIDTH-1:0]      lat_be;
    logic [DATA_WIDTH-1:0]    rsp_data;

    logic                     winner;
    logic                     accept;
    logic                     win_we;
    logic [DATA_WIDTH-1:0]    win_addr;
    logic [DATA_WIDTH-1:0]    win_wdata;
    logic [BE_WIDTH-1:0]      win_be;
    logic                     win_err;
    logic                     owner_rsp_ready;
    logic                     in_access;
    logic                     in_resp;

    // On a tie the port that was not granted last time wins.
    assign winner = (p0_req_valid && p1_req_valid) ? ~last_grant : p1_req_valid;
    assign accept = (state == IDLE) && (p0_req_valid || p1_req_valid);

    assign win_we    = winner ? p1_req_we    : p0_req_we;
    assign win_addr  = winner ? p1_req_addr  : p0_req_addr;
    assign win_wdata = winner ? p1_req_wdata : p0_req_wdata;
    assign win_be    = winner ? p1_req_be    : p0_req_be;
    assign win_err   = (win_addr[1:0] != 2'b00) || (|win_addr[DATA_WIDTH-1:ADDRESS_WIDTH+2]);

    // Ready is combinational, so it is also masked by rst_n to read 0 during reset.
    assign p0_req_ready = rst_n && accept && !winner;
    assign p1_req_ready = rst_n && accept &&  winner;

    assign owner_rsp_ready = owner ? p1_rsp_ready : p0_rsp_ready;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = win_err ? RESP : ACCESS;
            ACCESS:  state_next = lat_we ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    if (owner_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_widx   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            rsp_data   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= winner;
                owner      <= winner;
                lat_we     <= win_we;
                lat_err    <= win_err;
                lat_widx   <= win_addr[ADDRESS_WIDTH+1:2];
                lat_wdata  <= win_wdata;
                lat_be     <= win_be;
                rsp_data   <= '0;
            end
            if (state == WAIT) begin
                rsp_data <= mem_rdata;
            end
        end
    end

    assign in_access = (state == ACCESS);
    assign in_resp   = (state == RESP);

    assign mem_en    = in_access;
    assign mem_we    = in_access && lat_we;
    assign mem_be    = (in_access && lat_we) ? lat_be : '0;
    assign mem_addr  = in_access ? lat_widx  : '0;
    assign mem_wdata = in_access ? lat_wdata : '0;

    // Response outputs are steered to the owner only; the other port reads all zeros.
    assign p0_rsp_valid = in_resp && !owner;
    assign p0_rsp_err   = in_resp && !owner && lat_err;
    assign p0_rsp_rdata = (in_resp && !owner) ? rsp_data : '0;
    assign p1_rsp_valid = in_resp && owner;
    assign p1_rsp_err   = in_resp && owner && lat_err;
    assign p1_rsp_rdata = (in_resp && owner) ? rsp_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a memory model, timing checks in the stimulus
// thread, and a response scoreboard drained by an independent monitor.
module tb_dmem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          p0_req_valid, p0_req_ready, p0_req_we;
    logic [DW-1:0] p0_req_addr, p0_req_wdata;
    logic [BW-1:0] p0_req_be;
    logic          p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
    logic [DW-1:0] p0_rsp_rdata;

    logic          p1_req_valid, p1_req_ready, p1_req_we;
    logic [DW-1:0] p1_req_addr, p1_req_wdata;
    logic [BW-1:0] p1_req_be;
    logic          p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
    logic [DW-1:0] p1_rsp_rdata;

    logic          mem_en, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t exp_q0[$];
    rsp_t exp_q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] tb_mem [2**AW];

    dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_req_we    (p0_req_we),
        .p0_req_addr  (p0_req_addr),
        .p0_req_wdata (p0_req_wdata),
        .p0_req_be    (p0_req_be),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_ready (p0_rsp_ready),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p0_rsp_err   (p0_rsp_err),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_req_we    (p1_req_we),
        .p1_req_addr  (p1_req_addr),
        .p1_req_wdata (p1_req_wdata),
        .p1_req_be    (p1_req_be),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_ready (p1_rsp_ready),
        .p1_rsp_rdata (p1_rsp_rdata),
        .p1_rsp_err   (p1_rsp_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Single-ported memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= tb_mem[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int port, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (port == 0) begin
            p0_req_valid = v; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata; p0_req_be = be;
        end else begin
            p1_req_valid = v; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata; p1_req_be = be;
        end
    endtask

    task automatic push_exp(input int port, input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        if (port == 0) exp_q0.push_back(e);
        else           exp_q1.push_back(e);
    endtask

    // One transaction on an otherwise idle arbiter, with cycle-exact timing checks.
    task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [4:0] exp_widx, input string tag);
        bit   got;
        int   lat;
        logic rv;
        lat = exp_err ? 1 : (we ? 2 : 3);
        drive(port, 1'b1, we, addr, wdata, be);
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if ((port == 0) ? p0_req_ready : p1_req_ready) got = 1;
        end
        if (!got) begin
            check({tag, "_accept_timeout"}, 32'(got), 32'(1));
            drive(port, 1'b0, 1'b0, '0, '0, '0);
            return;
        end
        push_exp(port, exp_rdata, exp_err);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, '0, '0, '0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_mem_en"}, 32'(mem_en), 32'(!exp_err));
                if (!exp_err) begin
                    check({tag, "_mem_ctl"}, 32'({mem_we, mem_addr, mem_be}),
                          32'({we, exp_widx, (we ? be : 4'b0000)}));
                    if (we) check({tag, "_mem_wdata"}, mem_wdata, wdata);
                end
            end
            rv = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
            check({tag, "_rsp_valid_timing"}, 32'(rv), 32'(k == lat));
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compares whenever a response handshake is observed.
    always @(negedge clk) begin
        rsp_t e;
        if (p0_rsp_valid && p0_rsp_ready) begin
            if (exp_q0.size() == 0) begin
                check("p0_rsp_unexpected", 32'(p0_rsp_valid), 32'(0));
            end else begin
                e = exp_q0.pop_front();
                check("p0_rsp_rdata", p0_rsp_rdata, e.rdata);
                check("p0_rsp_err", 32'(p0_rsp_err), 32'(e.err));
                check("p1_rsp_quiet", 32'({p1_rsp_valid, p1_rsp_err, |p1_rsp_rdata}), 32'(0));
            end
        end
        if (p1_rsp_valid && p1_rsp_ready) begin
            if (exp_q1.size() == 0) begin
                check("p1_rsp_unexpected", 32'(p1_rsp_valid), 32'(0));
            end else begin
                e = exp_q1.pop_front();
                check("p1_rsp_rdata", p1_rsp_rdata, e.rdata);
                check("p1_rsp_err", 32'(p1_rsp_err), 32'(e.err));
                check("p0_rsp_quiet", 32'({p0_rsp_valid, p0_rsp_err, |p0_rsp_rdata}), 32'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] all_outputs_or();
        return 32'({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err,
                    |p0_rsp_rdata, |p1_rsp_rdata, mem_en, mem_we, |mem_be, |mem_addr, |mem_wdata});
    endfunction

    initial begin
        int   rel_cyc;
        int   last_acc;
        int   n;
        int   port;
        bit   got;
        logic rv;

        for (int i = 0; i < 2**AW; i++) tb_mem[i] = '0;
        tb_mem[2] = 32'hDEADBEEF;
        tb_mem[3] = 32'h0BADF00D;
        tb_mem[4] = 32'hAABBCCDD;

        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h8, '0, '0);
        drive(1, 1'b1, 1'b0, 32'hC, '0, '0);

        // Reset held with both ports requesting.
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", all_outputs_or(), 32'(0));

        // Round-robin with both ports loading continuously; first accept right after reset.
        @(posedge clk); #1;
        rst_n   = 1'b1;
        rel_cyc = cyc;
        last_acc = 0;
        for (int i = 0; i < 4; i++) begin
            got  = 0;
            port = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (p0_req_valid && p0_req_ready) begin port = 0; got = 1; end
                else if (p1_req_valid && p1_req_ready) begin port = 1; got = 1; end
            end
            if (!got) begin
                check("rr_accept_timeout", 32'(got), 32'(1));
                break;
            end
            n = cyc;
            if (i == 0) check("first_accept_after_reset", 32'(n), 32'(rel_cyc));
            else        check("rr_spacing", 32'(n - last_acc), 32'(4));
            last_acc = n;
            check("rr_grant_order", 32'(port), 32'(i % 2));
            check("rr_single_ready", 32'(p0_req_ready && p1_req_ready), 32'(0));
            push_exp(port, (port == 0) ? 32'hDEADBEEF : 32'h0BADF00D, 1'b0);
            if (i == 3) begin
                @(posedge clk); #1;
                drive(0, 1'b0, 1'b0, '0, '0, '0);
                drive(1, 1'b0, 1'b0, '0, '0, '0);
            end
            @(negedge clk);
            check("rr_mem_ctl", 32'({mem_en, mem_we, mem_addr, mem_be}),
                  32'({1'b1, 1'b0, ((port == 0) ? 5'd2 : 5'd3), 4'b0000}));
            @(negedge clk);
            rv = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
            check("rr_no_early_rsp", 32'(rv), 32'(0));
            @(negedge clk);
            rv = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
            check("rr_rsp_at_n3", 32'(rv), 32'(1));
        end
        @(posedge clk); #1;

        // Store with partial byte enables, then read back the merged word.
        do_txn(1, 1'b1, 32'h10, 32'h11223344, 4'b0011, 32'h0, 1'b0, 5'd4, "store");
        do_txn(1, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hAABB3344, 1'b0, 5'd4, "load_back");

        // Misaligned and out-of-range requests.
        do_txn(0, 1'b0, 32'h6, 32'h0, 4'b0000, 32'h0, 1'b1, 5'd0, "err_misalign");
        do_txn(0, 1'b0, 32'h80, 32'h0, 4'b0000, 32'h0, 1'b1, 5'd0, "err_range");
        do_txn(0, 1'b1, 32'h81, 32'h55, 4'b1111, 32'h0, 1'b1, 5'd0, "err_store");

        // Backpressure on p0 while p1 waits.
        p0_rsp_ready = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h8, '0, '0);
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (p0_req_ready) got = 1;
        end
        check("bp_accept", 32'(got), 32'(1));
        push_exp(0, 32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b1, 1'b0, 32'hC, '0, '0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_rsp_valid_held", 32'(p0_rsp_valid), 32'(1));
            check("bp_rsp_rdata_held", p0_rsp_rdata, 32'hDEADBEEF);
            check("bp_p1_held_off", 32'(p1_req_ready), 32'(0));
        end
        @(posedge clk); #1;
        p0_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_accept_on_completion", 32'(p1_req_ready), 32'(0));
        @(negedge clk);
        check("bp_p1_granted_next", 32'(p1_req_ready), 32'(1));
        if (p1_req_ready) push_exp(1, 32'h0BADF00D, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // Reset during WAIT of a load; the load must never answer.
        drive(0, 1'b1, 1'b0, 32'h8, '0, '0);
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (p0_req_ready) got = 1;
        end
        check("rst_wait_accept", 32'(got), 32'(1));
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'hC, '0, '0);
        @(negedge clk);
        check("rst_wait_access", 32'(mem_en), 32'(1));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs_zero", all_outputs_or(), 32'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_held_quiet", all_outputs_or(), 32'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tie_goes_p0", 32'({p0_req_ready, p1_req_ready}), 32'(2'b10));
        if (p0_req_ready) push_exp(0, 32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (8) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
